// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared defaults for the PWM block and its prescaler.
//   PWM_R_DEF          : default duty resolution in bits (period = 2^R ticks)
//   PWM_TIMER_BITS_DEF : default prescaler width
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_R_DEF          = 8;
    localparam int PWM_TIMER_BITS_DEF = 8;

endpackage : pwm_pkg

// File: rtl/pwm_timer.sv
// ---------------------------------------------------------------------------
// pwm_timer
// Programmable prescaler: produces a one-clock tick every final_value+1
// clocks.
// Ports:
//   clk_in      : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   final_value : terminal count (tick period = final_value+1 clocks)
//   tick        : high for the cycle in which the timer wraps
// ---------------------------------------------------------------------------
module pwm_timer
    import pwm_pkg::*;
#(
    parameter int TIMER_BITS = PWM_TIMER_BITS_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [TIMER_BITS-1:0] final_value,
    output logic                  tick
);

    logic [TIMER_BITS-1:0] timer_r;
    logic                  wrap_s;

    // A ">=" compare (not "==") means that lowering final_value below the
    // current count wraps on the next clock instead of rolling all the way
    // round the counter.
    assign wrap_s = (timer_r >= final_value);
    assign tick   = wrap_s;

    // Prescaler count register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TIMER_BITS{1'b0}};
        end else if (wrap_s) begin
            timer_r <= {TIMER_BITS{1'b0}};
        end else begin
            timer_r <= timer_r + TIMER_BITS'(1);
        end
    end

endmodule : pwm_timer

// File: rtl/pwm.sv
// ---------------------------------------------------------------------------
// pwm
// Pulse-width modulator. A prescaler tick advances an R-bit duty counter;
// the output is high while the counter is below the duty value.
// PWM period = 2^R * (final_value+1) clocks,
// high time  = duty_cycle * (final_value+1) clocks.
// Ports:
//   duty_cycle  : high ticks per period (0 .. 2^R-1)
//   final_value : prescaler terminal count
//   clk_in      : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   pwm_out     : registered PWM waveform
// Build option:
//   PWM_DUTY_LATCH_EN : when defined, duty_cycle is captured into a shadow
//                       register at each period start (and on reset release)
//                       so that duty updates never produce partial periods.
//                       When undefined, the live duty_cycle is compared.
// ---------------------------------------------------------------------------
module pwm
    import pwm_pkg::*;
#(
    parameter int R          = PWM_R_DEF,
    parameter int TIMER_BITS = PWM_TIMER_BITS_DEF
) (
    input  logic [R-1:0]          duty_cycle,
    input  logic [TIMER_BITS-1:0] final_value,
    input  logic                  clk_in,
    input  logic                  rst_n,
    output logic                  pwm_out
);

    logic         tick_s;
    logic [R-1:0] count_r;
    logic [R-1:0] duty_eff_s;
    logic         high_s;

    pwm_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_timer (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .final_value (final_value),
        .tick        (tick_s)
    );

    // Duty counter: advances once per prescaler tick, wraps naturally.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {R{1'b0}};
        end else if (tick_s) begin
            count_r <= count_r + R'(1);
        end else begin
            count_r <= count_r;
        end
    end

`ifdef PWM_DUTY_LATCH_EN
    logic [R-1:0] shadow_r;
    logic         load_r;   // set only for the first clock after reset release

    // Shadow duty register: loaded on reset release and when the counter
    // wraps to 0, so each period uses one consistent duty value.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {R{1'b0}};
            load_r   <= 1'b1;
        end else begin
            load_r <= 1'b0;
            if (load_r || (tick_s && (count_r == {R{1'b1}}))) begin
                shadow_r <= duty_cycle;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    // On the release clock the shadow still holds its reset value, so the
    // live duty is used for that one compare to keep the first period whole.
    always_comb begin
        duty_eff_s = shadow_r;
        if (load_r) begin
            duty_eff_s = duty_cycle;
        end else begin
            duty_eff_s = shadow_r;
        end
    end
`else
    // Live duty value feeds the compare directly.
    always_comb begin
        duty_eff_s = duty_cycle;
    end
`endif

    // Unsigned R-bit compare; duty 2^R-1 still leaves one low tick.
    always_comb begin
        high_s = 1'b0;
        if (count_r < duty_eff_s) begin
            high_s = 1'b1;
        end else begin
            high_s = 1'b0;
        end
    end

    // Output flop: pwm_out lags the compare by one clock.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= high_s;
        end
    end

endmodule : pwm

// File: tb/tb_pwm.sv
// ---------------------------------------------------------------------------
// tb_pwm
// Directed self-checking bench for pwm (R=8, TIMER_BITS=8). Outputs are
// sampled on the falling clock edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_pwm;

    logic [7:0] duty_cycle;
    logic [7:0] final_value;
    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       pwm_out;

    int checks = 0;
    int errors = 0;

    pwm #(
        .R          (8),
        .TIMER_BITS (8)
    ) dut (
        .duty_cycle  (duty_cycle),
        .final_value (final_value),
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .pwm_out     (pwm_out)
    );

    // 10 ns clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
    always #5 clk_in = ~clk_in;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold reset, check the output is low, release on a falling edge.
    task automatic apply_reset(input logic [7:0] duty, input logic [7:0] fv);
        rst_n       = 1'b0;
        duty_cycle  = duty;
        final_value = fv;
        repeat (3) @(negedge clk_in);
        check("reset_low", {31'd0, pwm_out}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Advance until a rising edge of pwm_out is sampled (bounded).
    task automatic wait_rise(input int budget, output int ok);
        logic prev;
        int   n;
        prev = pwm_out;
        ok   = 0;
        n    = 0;
        while (n < budget && ok == 0) begin
            @(negedge clk_in);
            n++;
            if (prev === 1'b0 && pwm_out === 1'b1) ok = 1;
            prev = pwm_out;
        end
    endtask

    // Called on the sample where pwm_out just rose: counts samples up to the
    // next rise (period) and the high samples within it. -1 on timeout.
    task automatic measure_period(input int budget, output int period, output int highs);
        logic prev;
        bit   done;
        prev   = pwm_out;
        period = 1;
        highs  = (pwm_out === 1'b1) ? 1 : 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk_in);
            if (prev === 1'b0 && pwm_out === 1'b1) begin
                done = 1'b1;
            end else begin
                period++;
                if (pwm_out === 1'b1) highs++;
                if (period > budget) begin
                    period = -1;
                    done   = 1'b1;
                end
            end
            prev = pwm_out;
        end
    endtask

    initial begin
        int ok;
        int per;
        int hi;
        int hc;
        bit stop;

        rst_n       = 1'b0;
        duty_cycle  = 8'd0;
        final_value = 8'd0;

        // 1) duty 64, final_value 194: period 256*195, high 64*195.
        apply_reset(8'd64, 8'd194);
        @(negedge clk_in);
        check("t1_first_high", {31'd0, pwm_out}, 32'd1);
        measure_period(60000, per, hi);
        check("t1_period", per, 32'd49920);
        check("t1_high", hi, 32'd12480);

        // 2) duty change 64 -> 128 at final_value 2 (period 768).
        apply_reset(8'd64, 8'd2);
        @(negedge clk_in);
        measure_period(2000, per, hi);
        check("t2_period64", per, 32'd768);
        check("t2_high64", hi, 32'd192);
        repeat (300) @(negedge clk_in);          // count = 100, low phase
        check("t2_low_before", {31'd0, pwm_out}, 32'd0);
        duty_cycle = 8'd128;
        @(negedge clk_in);
`ifdef PWM_DUTY_LATCH_EN
        check("t2_next_clock", {31'd0, pwm_out}, 32'd0);
`else
        check("t2_next_clock", {31'd0, pwm_out}, 32'd1);
`endif
        wait_rise(2000, ok);
        check("t2_rise", ok, 32'd1);
        measure_period(2000, per, hi);
        measure_period(2000, per, hi);
        check("t2_period128", per, 32'd768);
        check("t2_high128", hi, 32'd384);

        // 3) duty 192 at the same final_value.
        duty_cycle = 8'd192;
        wait_rise(2000, ok);
        check("t3_rise", ok, 32'd1);
        measure_period(2000, per, hi);
        measure_period(2000, per, hi);
        check("t3_period", per, 32'd768);
        check("t3_high", hi, 32'd576);

        // 4) final_value 0: duty 0 constant low, then duty 255.
        apply_reset(8'd0, 8'd0);
        hc = 0;
        repeat (600) begin
            @(negedge clk_in);
            if (pwm_out !== 1'b0) hc++;
        end
        check("t4_duty0_high", hc, 32'd0);
        duty_cycle = 8'd255;
        wait_rise(600, ok);
        check("t4_rise", ok, 32'd1);
        measure_period(600, per, hi);
        measure_period(600, per, hi);
        check("t4_period", per, 32'd256);
        check("t4_high", hi, 32'd255);

        // 5) final_value dropped 194 -> 10 while timer = 51 (duty 1).
        apply_reset(8'd1, 8'd194);
        @(negedge clk_in);
        check("t5_first_high", {31'd0, pwm_out}, 32'd1);
        hc = 1;
        repeat (50) begin
            @(negedge clk_in);
            if (pwm_out === 1'b1) hc++;
        end
        final_value = 8'd10;
        stop = 1'b0;
        while (!stop) begin
            @(negedge clk_in);
            if (pwm_out === 1'b1 && hc < 1000) hc++;
            else stop = 1'b1;
        end
        check("t5_high_len", hc, 32'd52);
        wait_rise(4000, ok);
        check("t5_rise", ok, 32'd1);
        measure_period(4000, per, hi);
        check("t5_period", per, 32'd2816);
        check("t5_high", hi, 32'd11);

        // 6) 2 ns async reset pulse mid-high-phase (duty 128, fv 2).
        apply_reset(8'd128, 8'd2);
        @(negedge clk_in);
        repeat (100) @(negedge clk_in);
        check("t6_high_before", {31'd0, pwm_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_drop", {31'd0, pwm_out}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        hc = (pwm_out === 1'b1) ? 1 : 0;
        stop = (hc == 0);
        while (!stop) begin
            @(negedge clk_in);
            if (pwm_out === 1'b1 && hc < 2000) hc++;
            else stop = 1'b1;
        end
        check("t6_restart_high", hc, 32'd384);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm
